// File: rtl/vad_energy.sv
// PDM-density voice activity detector.
// Frame energy from per-window |ones - midscale|, debounced level output.
module vad_energy #(
  parameter int WIN_LOG2       = 5,
  parameter int FRAME_LOG2     = 4,
  parameter int TRIGGER_FRAMES = 2,
  parameter int HANG_FRAMES    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           pdm_valid_i,
  input  logic                           pdm_data_i,
  input  logic [WIN_LOG2+FRAME_LOG2-1:0] thresh_i,
  output logic [WIN_LOG2+FRAME_LOG2-1:0] energy_o,
  output logic                           energy_valid_o,
  output logic                           vad_o
);

  localparam int W  = WIN_LOG2;
  localparam int F  = FRAME_LOG2;
  localparam int EW = W + F;
  localparam int TW = $clog2(TRIGGER_FRAMES + 1);
  localparam int HW = $clog2(HANG_FRAMES + 1);

  localparam logic [W:0]    HALF   = (W+1)'(2 ** (W - 1));
  localparam logic [TW-1:0] TRIG_N = TW'(TRIGGER_FRAMES);
  localparam logic [HW-1:0] HANG_N = HW'(HANG_FRAMES);

  typedef enum logic [1:0] {
    S_SILENT = 2'd0,
    S_ARMING = 2'd1,
    S_ACTIVE = 2'd2,
    S_HANG   = 2'd3
  } state_t;

  // window / frame datapath registers
  logic [W:0]    r_ones;
  logic [W-1:0]  r_bit_cnt;
  logic [F-1:0]  r_win_cnt;
  logic [EW-1:0] r_acc;
  logic [EW-1:0] r_energy;
  logic          r_ev;

  // debounce FSM registers
  state_t        r_state;
  logic [TW-1:0] r_trig;
  logic [HW-1:0] r_hang;
  logic          r_vad;

  // combinational helpers
  logic [W:0]    w_ones_final;
  logic [W:0]    w_dev;
  logic [EW-1:0] w_acc_sum;
  logic          w_last_bit;
  logic          w_last_win;
  logic          w_loud;
  logic [TW-1:0] w_trig_inc;
  logic [HW-1:0] w_hang_inc;
  state_t        w_state_n;
  logic [TW-1:0] w_trig_n;
  logic [HW-1:0] w_hang_n;
  logic          w_vad_n;

  assign w_ones_final = r_ones + {{W{1'b0}}, pdm_data_i};
  assign w_last_bit   = &r_bit_cnt;
  assign w_last_win   = &r_win_cnt;
  assign w_acc_sum    = r_acc + EW'(w_dev);
  assign w_loud       = r_energy > thresh_i;
  assign w_trig_inc   = r_trig + TW'(1);
  assign w_hang_inc   = r_hang + HW'(1);

  // distance of the window's ones count from midscale
  always_comb begin
    w_dev = '0;
    if (w_ones_final >= HALF) begin
      w_dev = w_ones_final - HALF;
    end else begin
      w_dev = HALF - w_ones_final;
    end
  end

  // bit/window counting and frame energy accumulation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ones    <= '0;
      r_bit_cnt <= '0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_energy  <= '0;
      r_ev      <= 1'b0;
    end else if (!en_i) begin
      r_ones    <= '0;
      r_bit_cnt <= '0;
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_energy  <= '0;
      r_ev      <= 1'b0;
    end else begin
      r_ev <= 1'b0;
      if (pdm_valid_i) begin
        r_bit_cnt <= r_bit_cnt + W'(1);
        if (w_last_bit) begin
          // window closes: restart ones count with no bit lost
          r_ones    <= '0;
          r_win_cnt <= r_win_cnt + F'(1);
          if (w_last_win) begin
            r_energy <= w_acc_sum;
            r_ev     <= 1'b1;
            r_acc    <= '0;
          end else begin
            r_acc <= w_acc_sum;
          end
        end else begin
          r_ones <= w_ones_final;
        end
      end
    end
  end

  // FSM state and debounce counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_SILENT;
      r_trig  <= '0;
      r_hang  <= '0;
      r_vad   <= 1'b0;
    end else if (!en_i) begin
      r_state <= S_SILENT;
      r_trig  <= '0;
      r_hang  <= '0;
      r_vad   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_trig  <= w_trig_n;
      r_hang  <= w_hang_n;
      r_vad   <= w_vad_n;
    end
  end

  // next-state: decisions only on the cycle after a frame completes
  always_comb begin
    w_state_n = r_state;
    w_trig_n  = r_trig;
    w_hang_n  = r_hang;
    if (r_ev) begin
      case (r_state)
        S_SILENT: begin
          if (w_loud) begin
            if (TRIGGER_FRAMES == 1) begin
              w_state_n = S_ACTIVE;
              w_trig_n  = '0;
            end else begin
              w_state_n = S_ARMING;
              w_trig_n  = TW'(1);
            end
          end
        end
        S_ARMING: begin
          if (w_loud) begin
            if (w_trig_inc == TRIG_N) begin
              w_state_n = S_ACTIVE;
              w_trig_n  = '0;
            end else begin
              w_trig_n = w_trig_inc;
            end
          end else begin
            w_state_n = S_SILENT;
            w_trig_n  = '0;
          end
        end
        S_ACTIVE: begin
          if (!w_loud) begin
            if (HANG_FRAMES == 1) begin
              w_state_n = S_SILENT;
              w_hang_n  = '0;
            end else begin
              w_state_n = S_HANG;
              w_hang_n  = HW'(1);
            end
          end
        end
        S_HANG: begin
          if (w_loud) begin
            w_state_n = S_ACTIVE;
            w_hang_n  = '0;
          end else if (w_hang_inc == HANG_N) begin
            w_state_n = S_SILENT;
            w_hang_n  = '0;
          end else begin
            w_hang_n = w_hang_inc;
          end
        end
        default: begin
          w_state_n = S_SILENT;
          w_trig_n  = '0;
          w_hang_n  = '0;
        end
      endcase
    end
  end

  // output decode from the next state so vad_o is a clean register
  always_comb begin
    w_vad_n = (w_state_n == S_ACTIVE) || (w_state_n == S_HANG);
  end

  assign energy_o       = r_energy;
  assign energy_valid_o = r_ev;
  assign vad_o          = r_vad;

endmodule
